// File: rtl/mult_driver.sv
// Initiator for the multiplier's valid_data / Done_Flag / ack four-phase handshake.
// Operands come in over valid/ready, and the product (or a timeout error) goes out over valid/ready.
module mult_driver #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 valid_data,
    input  logic                 Done_Flag,
    input  logic [2*WIDTH-1:0]   producto,
    output logic                 ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_producto,
    output logic                 out_error,
    output logic                 busy,
    output logic [15:0]          count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        OUT
    } state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_t               state;
    state_t               state_next;
    logic [15:0]          tcnt;
    logic [15:0]          tcnt_next;
    logic [WIDTH-1:0]     a_next;
    logic [WIDTH-1:0]     b_next;
    logic                 valid_data_next;
    logic                 ack_next;
    logic                 out_valid_next;
    logic [2*WIDTH-1:0]   out_producto_next;
    logic                 out_error_next;
    logic [15:0]          count_next;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Done_Flag is checked before the timeout, so a response on the last cycle still counts as success.
    always_comb begin
        state_next        = state;
        a_next            = a;
        b_next            = b;
        valid_data_next   = valid_data;
        ack_next          = ack;
        out_valid_next    = out_valid;
        out_producto_next = out_producto;
        out_error_next    = out_error;
        count_next        = count;
        tcnt_next         = tcnt;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_next          = in_a;
                    b_next          = in_b;
                    valid_data_next = 1'b1;
                    state_next      = REQ;
                end
            end
            REQ: begin
                if (Done_Flag) begin
                    out_producto_next = producto;
                    valid_data_next   = 1'b0;
                    ack_next          = 1'b1;
                    state_next        = ACK;
                end else if (tcnt == TLAST) begin
                    valid_data_next   = 1'b0;
                    out_producto_next = '0;
                    out_error_next    = 1'b1;
                    out_valid_next    = 1'b1;
                    state_next        = OUT;
                end
            end
            ACK: begin
                if (!Done_Flag) begin
                    ack_next       = 1'b0;
                    out_error_next = 1'b0;
                    out_valid_next = 1'b1;
                    state_next     = OUT;
                end else if (tcnt == TLAST) begin
                    ack_next       = 1'b0;
                    out_error_next = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    out_error_next = 1'b0;
                    count_next     = count + 16'd1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state) begin
            tcnt_next = '0;
        end else if (state == REQ || state == ACK) begin
            tcnt_next = tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a            <= '0;
            b            <= '0;
            valid_data   <= 1'b0;
            ack          <= 1'b0;
            out_valid    <= 1'b0;
            out_producto <= '0;
            out_error    <= 1'b0;
            count        <= '0;
            tcnt         <= '0;
        end else begin
            a            <= a_next;
            b            <= b_next;
            valid_data   <= valid_data_next;
            ack          <= ack_next;
            out_valid    <= out_valid_next;
            out_producto <= out_producto_next;
            out_error    <= out_error_next;
            count        <= count_next;
            tcnt         <= tcnt_next;
        end
    end

endmodule

// File: tb/tb_mult_driver.sv
// Directed bench for mult_driver: a behavioural multiplier answers the handshake with
// programmable delays, and every result is compared against hand-computed constants.
module tb_mult_driver;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic [31:0]   a;
    logic [31:0]   b;
    logic          valid_data;
    logic          Done_Flag;
    logic [63:0]   producto;
    logic          ack;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_producto;
    logic          out_error;
    logic          busy;
    logic [15:0]   count;

    int            checkCount = 0;
    int            errCount = 0;

    logic          modelDone;
    logic          pokeDone;
    bit            modelEnable;
    int            respDelay;
    int            ackDelay;
    int            vdCnt;
    int            ackCnt;
    int            overlapCnt;
    int            cyc;
    int            acceptQ[$];
    logic [63:0]   resQ[$];

    assign Done_Flag = modelDone | pokeDone;

    mult_driver #(
        .WIDTH   (32),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .a            (a),
        .b            (b),
        .valid_data   (valid_data),
        .Done_Flag    (Done_Flag),
        .producto     (producto),
        .ack          (ack),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_producto (out_producto),
        .out_error    (out_error),
        .busy         (busy),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Multiplier model: raises Done_Flag after respDelay request cycles, drops it after ackDelay ack cycles.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            modelDone <= 1'b0;
            producto  <= '0;
            vdCnt     <= 0;
            ackCnt    <= 0;
        end else begin
            if (valid_data && !modelDone) begin
                vdCnt <= vdCnt + 1;
                if (modelEnable && (vdCnt + 1 == respDelay)) begin
                    modelDone <= 1'b1;
                    producto  <= {32'd0, a} * {32'd0, b};
                end
            end else begin
                vdCnt <= 0;
            end
            if (modelDone && ack) begin
                ackCnt <= ackCnt + 1;
                if (ackCnt + 1 >= ackDelay) modelDone <= 1'b0;
            end else begin
                ackCnt <= 0;
                if (modelDone && !valid_data) modelDone <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid_data && ack) overlapCnt <= overlapCnt + 1;
        if (in_valid && in_ready) acceptQ.push_back(cyc);
        if (out_valid && out_ready) resQ.push_back(out_producto);
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase after the accept edge.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = x;
        in_b     = y;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("accept_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid(output int vdHigh, output int ackHigh);
        bit ok;
        ok      = 1'b0;
        vdHigh  = 0;
        ackHigh = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (valid_data) vdHigh++;
            if (ack) ackHigh++;
        end
        if (!ok) checkOutput("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vdHigh;
        int ackHigh;
        bit got3;

        reset       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b1;
        pokeDone    = 1'b0;
        modelEnable = 1'b1;
        respDelay   = 3;
        ackDelay    = 1;
        overlapCnt  = 0;
        cyc         = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid_data", 64'(valid_data), 64'd0);
        checkOutput("rst_ack", 64'(ack), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_out_producto", out_producto, 64'd0);
        #2 reset = 1'b1;
        syncDrive();

        // Single transaction, response 3 cycles after request
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitOutValid(vdHigh, ackHigh);
        checkOutput("single_vd_cycles", 64'(vdHigh), 64'd3);
        checkOutput("single_product", out_producto, 64'hFFFF_FFFE_0000_0001);
        checkOutput("single_error", 64'(out_error), 64'd0);
        @(negedge clk);
        checkOutput("single_count", 64'(count), 64'd1);
        checkOutput("single_in_ready", 64'(in_ready), 64'd1);
        syncDrive();

        // Back-to-back with a 1-cycle responder
        respDelay = 1;
        acceptQ.delete();
        resQ.delete();
        applyStimulus(32'd3, 32'd5);
        applyStimulus(32'd0, 32'h1234_5678);
        applyStimulus(32'h8000_0000, 32'd2);
        got3 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resQ.size() >= 3) begin
                got3 = 1'b1;
                break;
            end
        end
        checkOutput("b2b_results", 64'(resQ.size()), 64'd3);
        if (got3) begin
            checkOutput("b2b_res0", resQ[0], 64'd15);
            checkOutput("b2b_res1", resQ[1], 64'd0);
            checkOutput("b2b_res2", resQ[2], 64'h1_0000_0000);
        end
        if (acceptQ.size() >= 3) begin
            checkOutput("b2b_spacing01", 64'(acceptQ[1] - acceptQ[0]), 64'd4);
            checkOutput("b2b_spacing12", 64'(acceptQ[2] - acceptQ[1]), 64'd4);
        end else begin
            checkOutput("b2b_accepts", 64'(acceptQ.size()), 64'd3);
        end
        @(negedge clk);
        checkOutput("b2b_count", 64'(count), 64'd4);
        syncDrive();

        // Backpressure: out_ready low for 10 cycles after out_valid rises
        out_ready = 1'b0;
        applyStimulus(32'h0000_1234, 32'h0000_0010);
        waitOutValid(vdHigh, ackHigh);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_product", out_producto, 64'h1_2340);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_count", 64'(count), 64'd4);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_count_before", 64'(count), 64'd4);
        @(negedge clk);
        checkOutput("bp_count_after", 64'(count), 64'd5);
        checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);
        syncDrive();

        // Timeout in REQ: no response at all
        modelEnable = 1'b0;
        applyStimulus(32'd5, 32'd6);
        waitOutValid(vdHigh, ackHigh);
        checkOutput("treq_vd_cycles", 64'(vdHigh), 64'd8);
        checkOutput("treq_error", 64'(out_error), 64'd1);
        checkOutput("treq_product", out_producto, 64'd0);
        @(negedge clk);
        checkOutput("treq_count", 64'(count), 64'd6);
        checkOutput("treq_error_clear", 64'(out_error), 64'd0);
        syncDrive();
        modelEnable = 1'b1;

        // Spurious Done_Flag in IDLE is ignored
        pokeDone = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("spur_busy", 64'(busy), 64'd0);
            checkOutput("spur_ack", 64'(ack), 64'd0);
            checkOutput("spur_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1 pokeDone = 1'b0;
        @(negedge clk);
        checkOutput("spur_count", 64'(count), 64'd6);
        syncDrive();

        // Done_Flag on the same edge as the REQ timeout wins
        respDelay = 8;
        applyStimulus(32'h0000_1111, 32'd3);
        waitOutValid(vdHigh, ackHigh);
        checkOutput("simul_vd_cycles", 64'(vdHigh), 64'd8);
        checkOutput("simul_error", 64'(out_error), 64'd0);
        checkOutput("simul_product", out_producto, 64'h3333);
        @(negedge clk);
        checkOutput("simul_count", 64'(count), 64'd7);
        syncDrive();

        // Timeout in ACK: Done_Flag never drops, product is kept
        respDelay = 1;
        ackDelay  = 50;
        applyStimulus(32'd6, 32'd7);
        waitOutValid(vdHigh, ackHigh);
        checkOutput("tack_ack_cycles", 64'(ackHigh), 64'd8);
        checkOutput("tack_error", 64'(out_error), 64'd1);
        checkOutput("tack_product", out_producto, 64'd42);
        @(negedge clk);
        checkOutput("tack_count", 64'(count), 64'd8);
        syncDrive();

        // Asynchronous reset while in ACK
        ackDelay = 20;
        applyStimulus(32'd2, 32'd3);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        checkOutput("rmid_in_ack", 64'(ack), 64'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rmid_ack", 64'(ack), 64'd0);
        checkOutput("rmid_valid_data", 64'(valid_data), 64'd0);
        checkOutput("rmid_count", 64'(count), 64'd0);
        checkOutput("rmid_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rmid_a", 64'(a), 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        ackDelay = 1;
        syncDrive();
        applyStimulus(32'd7, 32'd9);
        waitOutValid(vdHigh, ackHigh);
        checkOutput("rmid_product", out_producto, 64'd63);
        checkOutput("rmid_error", 64'(out_error), 64'd0);
        @(negedge clk);
        checkOutput("rmid_count_after", 64'(count), 64'd1);

        checkOutput("no_overlap", 64'(overlapCnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mult_driver.md
# mult_driver

Initiator side of the multiplier's valid_data / Done_Flag / ack handshake. It accepts operand pairs from an upstream valid/ready source and drives them to a `multiplicador` instance. It completes the four-phase handshake, captures `producto`, and presents the result downstream over valid/ready. It replaces ad-hoc stimulus driving so that the multiplier can be embedded in datapaths, and it adds a timeout and a completed-transaction counter.

## Interface
- WIDTH, 32, operand width; the product is 2*WIDTH.
- TIMEOUT, 255, maximum cycles to wait in any handshake phase; must be 1..65535.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a, in_b  in  WIDTH  upstream operands.
- a, b  out  WIDTH  operands to the multiplier; held stable while valid_data or ack is high.
- valid_data  out  1  request to the multiplier.
- Done_Flag  in  1  multiplier result-valid.
- producto  in  2*WIDTH  multiplier result.
- ack  out  1  result accepted, to the multiplier.
- out_valid  out  1  result available downstream.
- out_ready  in  1  downstream accepts the result.
- out_producto  out  2*WIDTH  captured product; 0 on error.
- out_error  out  1  qualifies out_valid: the transaction timed out.
- busy  out  1  state is not IDLE.
- count  out  16  completed transactions, including errored ones; wraps modulo 2^16.

## Operation
- FSM states: IDLE, REQ, ACK, OUT.
- Timeout counter `tcnt`:
  - 16 bits.
  - Cleared on every state change.
  - Increments each cycle in REQ and ACK.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a/in_b into a/b, set valid_data=1, go to REQ.
  - Done_Flag is ignored in IDLE.
- REQ:
  - valid_data=1.
  - If Done_Flag=1: capture producto into out_producto, set valid_data=0 and ack=1, go to ACK.
  - Else if tcnt==TIMEOUT-1: set valid_data=0, out_producto=0, out_error=1, go to OUT.
  - Done_Flag takes priority over timeout in the same cycle.
- ACK:
  - ack=1.
  - If Done_Flag=0: set ack=0, go to OUT with out_error=0.
  - Else if tcnt==TIMEOUT-1: set ack=0, out_error=1, keep the captured product, go to OUT.
- OUT:
  - out_valid=1.
  - On out_ready: out_valid=0, out_error=0, count+1, go to IDLE.
  - out_producto holds its value until the next capture.
- valid_data and ack are never high in the same cycle.
- Reset (reset=0, any time, asynchronous):
  - State goes to IDLE.
  - a, b, out_producto, count, tcnt are cleared to 0.
  - valid_data, ack, out_valid, out_error, busy are 0.
  - in_ready is 1.
- A reset mid-handshake abandons the transaction; the multiplier is reset by the same net at system level.

## Timing
- All outputs are registered, except in_ready and busy, which decode the state register.
- Upstream accept edge E0 (in_valid & in_ready): valid_data and a/b are valid from E0 onward.
- First edge E1 with Done_Flag=1 sampled in REQ: after E1, ack=1 and valid_data=0. Minimum 1 cycle after E0.
- First edge E2 with Done_Flag=0 sampled in ACK: after E2, ack=0 and out_valid=1.
- Edge E3 with out_valid & out_ready: after E3, in_ready=1.
- A new operand pair is accepted no earlier than the edge after E3. Minimum issue interval is 4 cycles.
- Timeout in REQ: out_valid rises exactly TIMEOUT cycles after E0.
- No combinational path exists from Done_Flag or producto to any output.

## Test plan
- Reset then single transaction:
  - Stimulus: in_a=in_b=32'hFFFFFFFF. Model responds with Done_Flag 3 cycles after valid_data and drops it 1 cycle after ack.
  - Required: out_producto=64'hFFFFFFFE00000001, out_error=0, count=1. valid_data and ack never overlap.
- Back-to-back transactions with out_ready tied 1:
  - Stimulus: 3*5, then 0*32'h12345678, then 32'h80000000*2.
  - Required: results 15, 0, 64'h100000000 in order. Spacing of 4 cycles when the model responds in 1 cycle.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises.
  - Required: out_valid and out_producto stable, in_ready=0 throughout, count unchanged until out_ready=1.
- Timeout in REQ:
  - Stimulus: TIMEOUT=8, model never asserts Done_Flag.
  - Required: valid_data high for exactly 8 cycles, then out_valid=1, out_error=1, out_producto=0. count increments on accept.
- Reset mid-operation:
  - Stimulus: assert reset=0 asynchronously while in ACK.
  - Required: ack=0 and valid_data=0 immediately without a clock edge, count=0, in_ready=1. The next transaction 7*9 completes with 63.
- Spurious and simultaneous events:
  - Stimulus: Done_Flag pulses while in IDLE. Separately, Done_Flag arrives on the same edge as the REQ timeout.
  - Required: the IDLE pulse is ignored. The simultaneous case captures the product with out_error=0.
